lfsr_serializer: RTL and testbench

- Seeded 4-bit Galois LFSR scrambler with a serial output stage.
- On reset, the register loads a seed.
- After reset releases, the register advances a fixed number of LFSR steps, then shifts its final contents out LSB-first on a single-bit output, qualified by a valid strobe.
- The block is a standalone pseudo-random bit source or scrambler, used for simple on-chip test-pattern generation.

---
 rtl/lfsr_serializer.sv | 96 +++++++++
 tb/tb_lfsr_serializer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/lfsr_serializer.sv
// lfsr_serializer: seeded Galois LFSR scrambler with a serial output stage.
// After reset releases, the register is stepped SHIFTS times, then its final
// contents are presented LSB-first on OUT with valid high, one bit per clock.
// The block then idles with both outputs low until the next reset.
module lfsr_serializer #(
    parameter int               WIDTH  = 4,
    parameter int               SHIFTS = 8,
    parameter logic [WIDTH-1:0] TAPS   = 4'b0011
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] seed,
    output logic             OUT,
    output logic             valid
);

    // One counter serves both phases, so it must hold the larger of the two counts.
    localparam int MAX_COUNT = (SHIFTS > WIDTH) ? SHIFTS : WIDTH;
    localparam int CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SHIFTS - 1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_LFSR   = 2'd0,
        ST_SERIAL = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] lfsr_r;
    logic [CNT_W-1:0] cnt_r;

    // One Galois step: shift toward the MSB and fold the feedback mask back in
    // whenever the bit falling off the top was set.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] fb;
        fb = r[WIDTH-1] ? TAPS : {WIDTH{1'b0}};
        return {r[WIDTH-2:0], 1'b0} ^ fb;
    endfunction

    // Serial drain: move the next bit into position 0, zero filling from the top.
    function automatic logic [WIDTH-1:0] drain_step(input logic [WIDTH-1:0] r);
        return {1'b0, r[WIDTH-1:1]};
    endfunction

    // Sequencer: reset/seed load, LFSR stepping, serial output, then idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr_r  <= seed;
            cnt_r   <= CNT_ZERO;
            state_r <= ST_LFSR;
            OUT     <= 1'b0;
            valid   <= 1'b0;
        end else begin
            case (state_r)
                ST_LFSR: begin
                    lfsr_r <= lfsr_step(lfsr_r);
                    OUT    <= 1'b0;
                    valid  <= 1'b0;
                    if (cnt_r == LAST_SHIFT) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_SERIAL;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_SERIAL: begin
                    OUT    <= lfsr_r[0];
                    valid  <= 1'b1;
                    lfsr_r <= drain_step(lfsr_r);
                    if (cnt_r == LAST_BIT) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    OUT   <= 1'b0;
                    valid <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: park quietly until the next reset.
                    state_r <= ST_DONE;
                    cnt_r   <= CNT_ZERO;
                    OUT     <= 1'b0;
                    valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_serializer.sv
// Self-checking bench for lfsr_serializer: directed scenarios with known
// answers plus randomized seeds, hold lengths, mid-run resets and seed noise,
// all checked against an arithmetic reference model.
module tb_lfsr_serializer;

    localparam int WIDTH  = 4;
    localparam int SHIFTS = 8;
    localparam int TAPS   = 3;
    localparam int FULL   = SHIFTS + WIDTH + 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] seed;
    logic             out_bit;
    logic             valid;

    int vectors;
    int miscompares;

    lfsr_serializer #(
        .WIDTH (WIDTH),
        .SHIFTS(SHIFTS),
        .TAPS  (4'b0011)
    ) dut (
        .CLK  (clk),
        .RST  (rst),
        .seed (seed),
        .OUT  (out_bit),
        .valid(valid)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Register value after SHIFTS steps, treating the register as a polynomial
    // multiplied by x and reduced modulo x^4 + x + 1.
    function automatic int model_final(input int s);
        int r;
        r = s;
        for (int i = 0; i < SHIFTS; i++) begin
            r = r * 2;
            if (r >= (1 << WIDTH)) r = (r - (1 << WIDTH)) ^ TAPS;
        end
        return r;
    endfunction

    // Hold reset for 'hold' edges with seed s, then run 'run' edges expecting
    // the serial image of 'fin'. Optionally scramble seed while running.
    task automatic run_case(input int s, input int hold, input int run,
                            input int fin, input bit perturb);
        rst  = 1'b1;
        seed = WIDTH'(s);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("rst_valid", valid, 0);
            chk("rst_out", out_bit, 0);
        end
        rst = 1'b0;
        for (int k = 1; k <= run; k++) begin
            if (perturb) seed = WIDTH'($urandom);
            @(posedge clk); #1;
            if (k <= SHIFTS) begin
                chk("shift_valid", valid, 0);
                chk("shift_out", out_bit, 0);
            end else if (k <= SHIFTS + WIDTH) begin
                chk("ser_valid", valid, 1);
                chk("ser_out", out_bit, (fin >> (k - SHIFTS - 1)) & 1);
            end else begin
                chk("done_valid", valid, 0);
                chk("done_out", out_bit, 0);
            end
        end
    endtask

    initial begin
        int s;
        int hold;
        int run;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        seed        = 4'b0000;

        // Known answers: seed 1001 ends at 1011 -> bits 1,1,0,1.
        run_case(9, 1, FULL, 4'b1011, 1'b0);
        // Zero seed locks at zero but still emits four valid zeros.
        run_case(0, 1, FULL, 4'b0000, 1'b0);
        // Abort at edge 10 (mid-serial) and restart from seed 1000 -> 0,1,1,1.
        run_case(9, 1, 9, 4'b1011, 1'b0);
        run_case(8, 1, FULL, 4'b1110, 1'b0);
        // Seed noise while running must not disturb the output.
        run_case(9, 1, FULL, 4'b1011, 1'b1);
        // Long reset hold, then the same sequence as the first run.
        run_case(9, 5, FULL, 4'b1011, 1'b0);
        // Reference model agrees with the known answers above.
        chk("model_1001", model_final(9), 11);
        chk("model_1000", model_final(8), 14);

        // Randomized runs, including truncated runs that end in a new reset.
        for (int n = 0; n < 40; n++) begin
            s    = int'($urandom_range(0, 15));
            hold = int'($urandom_range(1, 3));
            run  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FULL)) : FULL;
            run_case(s, hold, run, model_final(s), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
